md_unit: RTL

- Multiply/divide unit and its sequencing controller for the pipelined MIPS core (EX stage).
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, models fixed multi-cycle latency with a busy counter, owns the HI/LO registers, and raises the stall request consumed by the hazard unit for MD-class instructions in ID.
- Instantiated inside mips alongside the ALU; observed by mips_tb only through architectural effects.

---
 rtl/md_defs.sv | 9 +
 rtl/md_arith.sv | 32 +++
 rtl/md_unit.sv | 65 ++++++
 3 files changed

// File: rtl/md_defs.sv
// md_defs: shared multiply/divide opcode encodings used by the decoder and the MD unit.
package md_defs;
  localparam logic [2:0] MD_OP_MULT  = 3'd0;
  localparam logic [2:0] MD_OP_MULTU = 3'd1;
  localparam logic [2:0] MD_OP_DIV   = 3'd2;
  localparam logic [2:0] MD_OP_DIVU  = 3'd3;
  localparam logic [2:0] MD_OP_MTHI  = 3'd4;
  localparam logic [2:0] MD_OP_MTLO  = 3'd5;
endpackage

// File: rtl/md_arith.sv
// md_arith: combinational 64-bit product and truncating quotient/remainder; ok=0 flags a zero divisor.
module md_arith
  import md_defs::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        ok
);
  logic        sgn, is_div, na, nb;
  logic [63:0] prod;
  logic [31:0] ma, mb, uq, ur, q, r;
  always_comb begin
    is_div = (op == MD_OP_DIV) | (op == MD_OP_DIVU);
    sgn    = (op == MD_OP_MULT) | (op == MD_OP_DIV);
    na     = sgn & a[31];
    nb     = sgn & b[31];
    // Product of sign-extended operands is exact modulo 2^64 for both flavours.
    prod   = (na ? {32'hFFFF_FFFF, a} : {32'h0, a}) * (nb ? {32'hFFFF_FFFF, b} : {32'h0, b});
    ma     = na ? -a : a;
    mb     = nb ? -b : b;
    ok     = !is_div | (b != 32'h0);
    uq     = (mb == 32'h0) ? 32'h0 : ma / mb;
    ur     = (mb == 32'h0) ? 32'h0 : ma % mb;
    q      = (na ^ nb) ? -uq : uq;
    r      = na ? -ur : ur;
    res_hi = is_div ? r : prod[63:32];
    res_lo = is_div ? q : prod[31:0];
  end
endmodule

// File: rtl/md_unit.sv
// md_unit: MIPS EX-stage multiply/divide sequencer owning HI/LO with a fixed-latency busy counter.
module md_unit
  import md_defs::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_d,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      pending_hi, pending_lo, res_hi, res_lo;
  logic             res_ok, start_mul_div;
  md_arith u_arith (
    .op     (md_op),
    .a      (rs_val),
    .b      (rt_val),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .ok     (res_ok)
  );
  assign busy          = (state == BUSY);
  assign start_mul_div = start & (md_op <= MD_OP_DIVU);
  assign md_stall      = md_use_d & (busy | start_mul_div);
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      hi         <= '0;
      lo         <= '0;
      pending_hi <= '0;
      pending_lo <= '0;
    end else if (busy) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        state <= IDLE;
        hi    <= pending_hi;
        lo    <= pending_lo;
      end
    end else if (start_mul_div) begin
      state      <= BUSY;
      cnt        <= md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      // A zero divisor latches the current HI/LO so completion rewrites them unchanged.
      pending_hi <= res_ok ? res_hi : hi;
      pending_lo <= res_ok ? res_lo : lo;
    end else if (start && md_op == MD_OP_MTHI) begin
      hi <= rs_val;
    end else if (start && md_op == MD_OP_MTLO) begin
      lo <= rs_val;
    end
  end
endmodule
